aha_sram_arbiter: RTL and testbench
===================================

Name: aha_sram_arbiter

Overview:
- Shares one 64K-byte, 32-bit SRAM array (16K words, SRAM-style interface with 1-cycle read latency) between two requesters: port 0 (AHB-to-SRAM bridge, CPU) and port 1 (DMA/test engine).
- Sits between the requesters and the bank-decoded SRAM wrapper, driving that wrapper's SRAMADDR/SRAMWEN/SRAMWDATA/SRAMCS and returning SRAMRDATA.
- Uses round-robin arbitration with a per-port req/gnt handshake and read-data steering.

Parameters:
- AW, 14, word address width (16K words).
- MAX_HOLD, 4, maximum consecutive grants to one port when AHA_SRAM_ARB_HOLD_EN is defined (1..15).

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- m0_req  in  1  port 0 access request (level).
- m0_addr  in  AW  port 0 word address.
- m0_we  in  4  port 0 byte write enables; 0 = read.
- m0_wdata  in  32  port 0 write data.
- m0_gnt  out  1  port 0 request accepted this cycle.
- m0_rvalid  out  1  port 0 read data valid.
- m0_rdata  out  32  port 0 read data.
- m1_req, m1_addr, m1_we, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1.
- sram_cs  out  1  SRAM chip select.
- sram_addr  out  AW  SRAM word address.
- sram_we  out  4  SRAM byte write enables.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data, valid the cycle after a read select.

Behaviour:
- Clock and reset: one clock, HCLK; HRESETn is asynchronous, active-low.
- Reset values: last_gnt = port 1, so port 0 wins first; rd_pending = 0; rd_owner = 0; hold_cnt = 0; all gnt/rvalid = 0; rdata = 0.
- Grant (combinational, same cycle as req):
  - Only port 0 requesting: m0_gnt = 1.
  - Only port 1 requesting: m1_gnt = 1.
  - Both requesting: grant the port not in last_gnt.
  - At most one gnt is high per cycle.
  - A requester with req high and gnt low must hold addr/we/wdata stable until granted.
- SRAM drive:
  - sram_cs = m0_gnt | m1_gnt.
  - sram_addr, sram_we, sram_wdata are muxed from the granted port.
  - With no grant, addr and wdata are 0 and we = 0.
- last_gnt updates on every granted cycle.
- Reads:
  - A grant with we == 0 registers rd_pending = 1 and rd_owner = the granted port.
  - Next cycle: mX_rvalid = 1 for rd_owner only, and mX_rdata = sram_rdata.
  - The non-owner's rdata is 0 and is masked whenever rvalid = 0.
- Latency and throughput:
  - Exactly 1 cycle from grant to rvalid.
  - Back-to-back reads from alternating ports give one grant per cycle and one rvalid per cycle, steered correctly.
- Writes: complete in the grant cycle; no rvalid.
- Idle: a cycle with no req leaves last_gnt unchanged.
- Simultaneous read return and new grant: allowed; they are independent pipeline stages.
- Reset mid-operation: pending rvalid is dropped; outputs go to their reset values immediately.

Optional Feature:
- Macro: AHA_SRAM_ARB_HOLD_EN.
- Defined:
  - The port that won the last grant keeps priority while it keeps req high, for up to MAX_HOLD consecutive grants.
  - hold_cnt counts consecutive grants to the same port.
  - When hold_cnt reaches MAX_HOLD and the other port is requesting, the other port wins and hold_cnt resets to 1.
  - hold_cnt resets to 0 on an idle cycle.
- Not defined: pure alternation, as above; hold_cnt is absent.

Decomposition:
- Package aha_sram_arb_pkg:
  - localparam NUM_PORTS = 2.
  - Port-index type.
  - sram_req_t struct {addr, we, wdata}.
- One sub-module, aha_sram_rr_pick:
  - Combinational 2-way round-robin picker, with the hold counter under the macro.
  - The top module holds the mux, read-return pipeline and state.

Test Plan:
- Reset, then m0 read of addr 0x0010 (memory preloaded with 0x11223344): m0_gnt same cycle, then m0_rvalid = 1 with m0_rdata = 0x11223344 next cycle; m1_rvalid stays 0.
- Both ports request continuously:
  - Without the macro, gnt alternates m0, m1, m0, m1.
  - With the macro and MAX_HOLD = 4, the pattern is m0 x4 then m1 x4.
- m1 writes 0xDEADBEEF to 0x3FFF with we = 4'b0011, then m0 reads 0x3FFF: read returns 0x????BEEF, low half updated, upper bytes preserved.
- Alternating reads m0 @0x0001, m1 @0x1000, m0 @0x2001: rvalid is steered to owners in order, with no data swap.
- HRESETn asserted in the cycle after a read grant: no rvalid is produced; all outputs are 0 while reset is held.
- Idle gap: m1 is granted, then 3 idle cycles, then both request: m0 wins.

Source files
------------

// File: rtl/aha_sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// Optional hold-priority feature is selected with AHA_SRAM_ARB_HOLD_EN.
package aha_sram_arb_pkg;

  localparam int NUM_PORTS = 2;
  localparam int SRAM_AW   = 14;
  localparam int HOLD_W    = 4;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_idx_t;

  typedef struct packed {
    logic [SRAM_AW-1:0] addr;
    logic [3:0]         we;
    logic [31:0]        wdata;
  } sram_req_t;

endpackage

// File: rtl/aha_sram_rr_pick.sv
// Combinational 2-way round-robin picker; with AHA_SRAM_ARB_HOLD_EN the last
// winner keeps priority for up to MAX_HOLD consecutive grants.
module aha_sram_rr_pick
  import aha_sram_arb_pkg::*;
#(
`ifdef AHA_SRAM_ARB_HOLD_EN
  parameter int MAX_HOLD = 4
`endif
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  port_idx_t            i_last,
`ifdef AHA_SRAM_ARB_HOLD_EN
  input  logic [HOLD_W-1:0]    i_hold_cnt,
  output logic [HOLD_W-1:0]    o_hold_cnt_nxt,
`endif
  output logic [NUM_PORTS-1:0] o_gnt,
  output port_idx_t            o_winner
);

`ifdef AHA_SRAM_ARB_HOLD_EN
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
`endif

  port_idx_t w_other;
  port_idx_t w_pref;

  // Pick the winner; a zero hold count (after reset or idle) means plain alternation.
  always_comb begin
    w_other  = (i_last == PORT0) ? PORT1 : PORT0;
`ifdef AHA_SRAM_ARB_HOLD_EN
    w_pref   = ((i_hold_cnt != 4'd0) && (i_hold_cnt < HOLD_MAX)) ? i_last : w_other;
`else
    w_pref   = w_other;
`endif
    o_gnt    = 2'b00;
    o_winner = i_last;
    case (i_req)
      2'b01: begin
        o_gnt    = 2'b01;
        o_winner = PORT0;
      end
      2'b10: begin
        o_gnt    = 2'b10;
        o_winner = PORT1;
      end
      2'b11: begin
        o_gnt    = (w_pref == PORT0) ? 2'b01 : 2'b10;
        o_winner = w_pref;
      end
      default: begin
        o_gnt    = 2'b00;
        o_winner = i_last;
      end
    endcase
`ifdef AHA_SRAM_ARB_HOLD_EN
    if (i_req == 2'b00) begin
      o_hold_cnt_nxt = 4'd0;
    end else if ((o_winner == i_last) && (i_hold_cnt != 4'd0)) begin
      o_hold_cnt_nxt = (i_hold_cnt == HOLD_MAX) ? HOLD_MAX : (i_hold_cnt + 4'd1);
    end else begin
      o_hold_cnt_nxt = 4'd1;
    end
`endif
  end

endmodule

// File: rtl/aha_sram_arbiter.sv
// Two-port round-robin SRAM arbiter with 1-cycle read-data steering.
// Define AHA_SRAM_ARB_HOLD_EN to let the last winner hold priority for MAX_HOLD grants.
module aha_sram_arbiter
  import aha_sram_arb_pkg::*;
#(
  parameter int AW       = SRAM_AW,
  parameter int MAX_HOLD = 4
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [3:0]    m0_we,
  input  logic [31:0]   m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [3:0]    m1_we,
  input  logic [31:0]   m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic          sram_cs,
  output logic [AW-1:0] sram_addr,
  output logic [3:0]    sram_we,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  if ((AW != SRAM_AW) || (MAX_HOLD < 1) || (MAX_HOLD > 15)) begin : g_param_check
    $error("aha_sram_arbiter: unsupported AW or MAX_HOLD");
  end

  logic [NUM_PORTS-1:0] w_req;
  logic [NUM_PORTS-1:0] w_gnt;
  port_idx_t            w_winner;
  sram_req_t            w_m0;
  sram_req_t            w_m1;
  sram_req_t            w_sel;
  port_idx_t            r_last_gnt;
  port_idx_t            r_rd_owner;
  logic                 r_rd_pending;
`ifdef AHA_SRAM_ARB_HOLD_EN
  logic [HOLD_W-1:0]    r_hold_cnt;
  logic [HOLD_W-1:0]    w_hold_cnt_nxt;
`endif

  // Requests are masked during reset so every output reads 0 while HRESETn is low.
  assign w_req = {m1_req, m0_req} & {NUM_PORTS{HRESETn}};
  assign w_m0  = '{addr: m0_addr, we: m0_we, wdata: m0_wdata};
  assign w_m1  = '{addr: m1_addr, we: m1_we, wdata: m1_wdata};

  aha_sram_rr_pick
`ifdef AHA_SRAM_ARB_HOLD_EN
    #(.MAX_HOLD(MAX_HOLD))
`endif
  u_pick (
    .i_req          (w_req),
    .i_last         (r_last_gnt),
`ifdef AHA_SRAM_ARB_HOLD_EN
    .i_hold_cnt     (r_hold_cnt),
    .o_hold_cnt_nxt (w_hold_cnt_nxt),
`endif
    .o_gnt          (w_gnt),
    .o_winner       (w_winner)
  );

  // Steer the granted port's command onto the SRAM; idle drives all zeros.
  always_comb begin
    w_sel = '0;
    case (w_gnt)
      2'b01:   w_sel = w_m0;
      2'b10:   w_sel = w_m1;
      default: w_sel = '0;
    endcase
  end

  assign m0_gnt     = w_gnt[0];
  assign m1_gnt     = w_gnt[1];
  assign sram_cs    = |w_gnt;
  assign sram_addr  = w_sel.addr;
  assign sram_we    = w_sel.we;
  assign sram_wdata = w_sel.wdata;

  // Arbitration history and the one-deep read-return stage.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_last_gnt   <= PORT1;
      r_rd_owner   <= PORT0;
      r_rd_pending <= 1'b0;
    end else begin
      r_rd_pending <= sram_cs && (w_sel.we == 4'b0000);
      if (sram_cs) begin
        r_last_gnt <= w_winner;
        if (w_sel.we == 4'b0000) begin
          r_rd_owner <= w_winner;
        end
      end
    end
  end

`ifdef AHA_SRAM_ARB_HOLD_EN
  // Consecutive-grant counter for the hold-priority policy.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_hold_cnt <= 4'd0;
    end else begin
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end
`endif

  assign m0_rvalid = r_rd_pending && (r_rd_owner == PORT0);
  assign m1_rvalid = r_rd_pending && (r_rd_owner == PORT1);
  assign m0_rdata  = m0_rvalid ? sram_rdata : 32'h0000_0000;
  assign m1_rdata  = m1_rvalid ? sram_rdata : 32'h0000_0000;

endmodule

// File: tb/tb_aha_sram_arbiter.sv
// Self-checking bench for aha_sram_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model (grant order + word memory).
module tb_aha_sram_arbiter;

  localparam int AW       = 14;
  localparam int MAX_HOLD = 4;
  localparam int DEPTH    = 1 << AW;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          m0_req, m1_req;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [3:0]    m0_we, m1_we;
  logic [31:0]   m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          sram_cs;
  logic [AW-1:0] sram_addr;
  logic [3:0]    sram_we;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata_q = 32'h0;

  int errors = 0;
  int checks = 0;

  logic [31:0] sram_mem [DEPTH];
  logic [31:0] ref_mem  [DEPTH];
  logic        mem_loaded = 1'b0;

  // Reference model state: last winner, streak of consecutive grants, pending read return.
  int          m_last;
  int          m_streak;
  logic        m_rv_valid;
  int          m_rv_owner;
  logic [31:0] m_rv_data;

  aha_sram_arbiter #(.AW(AW), .MAX_HOLD(MAX_HOLD)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .sram_cs(sram_cs), .sram_addr(sram_addr), .sram_we(sram_we),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata_q)
  );

  always #5 HCLK = ~HCLK;

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'h1122_3344;
    return 32'hA5C3_0000 ^ 32'(i * 32'h0001_0003);
  endfunction

  // SRAM model: byte-write, 1-cycle read latency.
  always @(posedge HCLK) begin
    if (!mem_loaded) begin
      for (int i = 0; i < DEPTH; i++) sram_mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (sram_cs) begin
      if (sram_we == 4'b0000) begin
        sram_rdata_q <= sram_mem[sram_addr];
      end else begin
        for (int b = 0; b < 4; b++)
          if (sram_we[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
    end
  end

  task automatic drive_port(input int p, input logic req, input logic [AW-1:0] addr,
                            input logic [3:0] we, input logic [31:0] wdata);
    if (p == 0) begin
      m0_req = req; m0_addr = addr; m0_we = we; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_addr = addr; m1_we = we; m1_wdata = wdata;
    end
  endtask

  task automatic drive_idle();
    drive_port(0, 1'b0, '0, 4'b0000, 32'h0);
    drive_port(1, 1'b0, '0, 4'b0000, 32'h0);
  endtask

  task automatic apply_reset();
    HRESETn = 1'b0;
    drive_idle();
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    m_last = 1; m_streak = 0; m_rv_valid = 1'b0; m_rv_owner = 0; m_rv_data = 32'h0;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    drive_port(0, 1'b1, 14'h0010, 4'b0000, 32'h0);
    drive_port(1, 1'b1, 14'h0020, 4'b1111, 32'h1234_5678);
    @(negedge HCLK);
    checks++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
         sram_cs, sram_addr, sram_we, sram_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b%b rv=%b%b cs=%b addr=%h we=%b expected all 0",
               m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, sram_cs, sram_addr, sram_we);
    end
    apply_reset();
    @(negedge HCLK);
    checks++;
    if ({m0_rvalid, m1_rvalid, sram_cs} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release_idle: got rv=%b%b cs=%b expected 000", m1_rvalid, m0_rvalid, sram_cs);
    end
  endtask

  task automatic test_single_read();
    @(posedge HCLK); #1;
    drive_port(0, 1'b1, 14'h0010, 4'b0000, 32'h0);
    @(negedge HCLK);
    checks++;
    if ({m1_gnt, m0_gnt, sram_cs, sram_addr} !== {2'b01, 1'b1, 14'h0010}) begin
      errors++;
      $display("FAIL single_read_gnt: got gnt=%b%b cs=%b addr=%h expected 01 1 0010",
               m1_gnt, m0_gnt, sram_cs, sram_addr);
    end
    @(posedge HCLK); #1;
    drive_idle();
    @(negedge HCLK);
    checks++;
    if ({m1_rvalid, m0_rvalid} !== 2'b01 || m0_rdata !== 32'h1122_3344 || m1_rdata !== 32'h0) begin
      errors++;
      $display("FAIL single_read_data: got rv=%b%b rdata0=%h rdata1=%h expected 01 11223344 0",
               m1_rvalid, m0_rvalid, m0_rdata, m1_rdata);
    end
  endtask

  task automatic test_contention();
    int exp_w, prev_w;
    logic [31:0] exp_d;
    apply_reset();
    drive_port(0, 1'b1, 14'h0020, 4'b0000, 32'h0);
    drive_port(1, 1'b1, 14'h0030, 4'b0000, 32'h0);
    prev_w = -1;
    for (int i = 0; i < 8; i++) begin
`ifdef AHA_SRAM_ARB_HOLD_EN
      exp_w = (i / MAX_HOLD) % 2;
`else
      exp_w = i % 2;
`endif
      @(negedge HCLK);
      checks++;
      if ({m1_gnt, m0_gnt} !== ((exp_w == 1) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL contention_gnt[%0d]: got %b%b expected port %0d", i, m1_gnt, m0_gnt, exp_w);
      end
      if (prev_w >= 0) begin
        exp_d = init_word((prev_w == 1) ? 32'h30 : 32'h20);
        checks++;
        if ({m1_rvalid, m0_rvalid} !== ((prev_w == 1) ? 2'b10 : 2'b01) ||
            ((prev_w == 1) ? m1_rdata : m0_rdata) !== exp_d) begin
          errors++;
          $display("FAIL contention_rvalid[%0d]: got rv=%b%b d0=%h d1=%h expected owner %0d data %h",
                   i, m1_rvalid, m0_rvalid, m0_rdata, m1_rdata, prev_w, exp_d);
        end
      end
      prev_w = exp_w;
      @(posedge HCLK); #1;
    end
    drive_idle();
  endtask

  task automatic test_partial_write();
    logic [31:0] init_v, exp_v;
    init_v = init_word(32'h3FFF);
    exp_v  = {init_v[31:16], 16'hBEEF};
    @(posedge HCLK); #1;
    drive_port(1, 1'b1, 14'h3FFF, 4'b0011, 32'hDEAD_BEEF);
    @(negedge HCLK);
    checks++;
    if ({m1_gnt, m0_gnt, sram_we, sram_wdata, sram_addr} !== {2'b10, 4'b0011, 32'hDEAD_BEEF, 14'h3FFF}) begin
      errors++;
      $display("FAIL write_drive: got gnt=%b%b we=%b wdata=%h addr=%h expected 10 0011 deadbeef 3fff",
               m1_gnt, m0_gnt, sram_we, sram_wdata, sram_addr);
    end
    @(posedge HCLK); #1;
    drive_port(1, 1'b0, '0, 4'b0000, 32'h0);
    drive_port(0, 1'b1, 14'h3FFF, 4'b0000, 32'h0);
    @(negedge HCLK);
    checks++;
    if ({m1_gnt, m0_gnt, m1_rvalid, m0_rvalid} !== 4'b0100) begin
      errors++;
      $display("FAIL write_no_rvalid: got gnt=%b%b rv=%b%b expected gnt 01 rv 00",
               m1_gnt, m0_gnt, m1_rvalid, m0_rvalid);
    end
    @(posedge HCLK); #1;
    drive_idle();
    @(negedge HCLK);
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== exp_v) begin
      errors++;
      $display("FAIL partial_write_readback: got rv=%b data=%h expected 1 %h", m0_rvalid, m0_rdata, exp_v);
    end
    ref_mem[14'h3FFF] = exp_v;
  endtask

  task automatic test_alternating_reads();
    logic [AW-1:0] addrs [3];
    int owners [3];
    addrs[0] = 14'h0001; addrs[1] = 14'h1000; addrs[2] = 14'h2001;
    owners[0] = 0; owners[1] = 1; owners[2] = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge HCLK); #1;
      drive_idle();
      if (i < 3) drive_port(owners[i], 1'b1, addrs[i], 4'b0000, 32'h0);
      @(negedge HCLK);
      if (i < 3) begin
        checks++;
        if ({m1_gnt, m0_gnt} !== ((owners[i] == 1) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL alt_gnt[%0d]: got %b%b expected port %0d", i, m1_gnt, m0_gnt, owners[i]);
        end
      end
      if (i > 0) begin
        checks++;
        if ({m1_rvalid, m0_rvalid} !== ((owners[i-1] == 1) ? 2'b10 : 2'b01) ||
            ((owners[i-1] == 1) ? m1_rdata : m0_rdata) !== init_word(int'(addrs[i-1])) ||
            ((owners[i-1] == 1) ? m0_rdata : m1_rdata) !== 32'h0) begin
          errors++;
          $display("FAIL alt_rdata[%0d]: got rv=%b%b d0=%h d1=%h expected owner %0d data %h",
                   i, m1_rvalid, m0_rvalid, m0_rdata, m1_rdata, owners[i-1], init_word(int'(addrs[i-1])));
        end
      end
    end
    @(posedge HCLK); #1;
    drive_idle();
  endtask

  task automatic test_reset_mid_read();
    drive_port(0, 1'b1, 14'h0005, 4'b0000, 32'h0);
    @(negedge HCLK);
    checks++;
    if (m0_gnt !== 1'b1) begin
      errors++;
      $display("FAIL midreset_gnt: got %b expected 1", m0_gnt);
    end
    @(posedge HCLK); #1;
    HRESETn = 1'b0;
    drive_port(1, 1'b1, 14'h0006, 4'b0000, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge HCLK);
      checks++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
           sram_cs, sram_addr, sram_we, sram_wdata} !== '0) begin
        errors++;
        $display("FAIL midreset_outputs[%0d]: got gnt=%b%b rv=%b%b cs=%b d0=%h expected all 0",
                 i, m1_gnt, m0_gnt, m1_rvalid, m0_rvalid, sram_cs, m0_rdata);
      end
      @(posedge HCLK); #1;
    end
    drive_idle();
    HRESETn = 1'b1;
    @(negedge HCLK);
    checks++;
    if ({m1_rvalid, m0_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL midreset_no_rvalid: got %b%b expected 00", m1_rvalid, m0_rvalid);
    end
  endtask

  task automatic test_idle_gap();
    apply_reset();
    drive_port(1, 1'b1, 14'h0100, 4'b0000, 32'h0);
    @(negedge HCLK);
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL idle_first_gnt: got %b%b expected 10", m1_gnt, m0_gnt);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge HCLK); #1;
      drive_idle();
      @(negedge HCLK);
      checks++;
      if ({m1_gnt, m0_gnt, sram_cs, sram_addr, sram_we, sram_wdata} !== '0) begin
        errors++;
        $display("FAIL idle_drive[%0d]: got gnt=%b%b cs=%b addr=%h we=%b wdata=%h expected all 0",
                 i, m1_gnt, m0_gnt, sram_cs, sram_addr, sram_we, sram_wdata);
      end
    end
    @(posedge HCLK); #1;
    drive_port(0, 1'b1, 14'h0200, 4'b0000, 32'h0);
    drive_port(1, 1'b1, 14'h0300, 4'b0000, 32'h0);
    @(negedge HCLK);
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL idle_then_both: got %b%b expected 01", m1_gnt, m0_gnt);
    end
    @(posedge HCLK); #1;
    drive_idle();
  endtask

  task automatic test_random();
    logic          p_act [2];
    logic [AW-1:0] p_addr [2];
    logic [3:0]    p_we [2];
    logic [31:0]   p_wdata [2];
    int            w;
    logic [AW-1:0] e_addr;
    logic [3:0]    e_we;
    logic [31:0]   e_wdata, e_rd0, e_rd1, tmp;
    apply_reset();
    p_act[0] = 1'b0; p_act[1] = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!p_act[p] && ($urandom_range(0, 3) != 0)) begin
          p_act[p]   = 1'b1;
          p_addr[p]  = AW'($urandom_range(0, 15));
          p_we[p]    = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
          p_wdata[p] = $urandom;
        end
        if (p_act[p]) drive_port(p, 1'b1, p_addr[p], p_we[p], p_wdata[p]);
        else          drive_port(p, 1'b0, '0, 4'b0000, 32'h0);
      end
      if (p_act[0] && p_act[1]) begin
`ifdef AHA_SRAM_ARB_HOLD_EN
        w = (m_streak > 0 && m_streak < MAX_HOLD) ? m_last : 1 - m_last;
`else
        w = 1 - m_last;
`endif
      end else if (p_act[0]) w = 0;
      else if (p_act[1])     w = 1;
      else                   w = -1;
      e_addr  = (w >= 0) ? p_addr[w]  : '0;
      e_we    = (w >= 0) ? p_we[w]    : 4'b0000;
      e_wdata = (w >= 0) ? p_wdata[w] : 32'h0;
      e_rd0   = (m_rv_valid && m_rv_owner == 0) ? m_rv_data : 32'h0;
      e_rd1   = (m_rv_valid && m_rv_owner == 1) ? m_rv_data : 32'h0;
      @(negedge HCLK);
      checks++;
      if ({m1_gnt, m0_gnt} !== {w == 1, w == 0}) begin
        errors++;
        $display("FAIL rand_gnt[%0d]: got %b%b expected winner %0d", cyc, m1_gnt, m0_gnt, w);
      end
      checks++;
      if ({sram_cs, sram_addr, sram_we, sram_wdata} !== {w >= 0, e_addr, e_we, e_wdata}) begin
        errors++;
        $display("FAIL rand_sram[%0d]: got cs=%b addr=%h we=%b wdata=%h expected %b %h %b %h",
                 cyc, sram_cs, sram_addr, sram_we, sram_wdata, w >= 0, e_addr, e_we, e_wdata);
      end
      checks++;
      if ({m1_rvalid, m0_rvalid} !== {m_rv_valid && m_rv_owner == 1, m_rv_valid && m_rv_owner == 0} ||
          m0_rdata !== e_rd0 || m1_rdata !== e_rd1) begin
        errors++;
        $display("FAIL rand_rdata[%0d]: got rv=%b%b d0=%h d1=%h expected valid=%b owner=%0d d0=%h d1=%h",
                 cyc, m1_rvalid, m0_rvalid, m0_rdata, m1_rdata, m_rv_valid, m_rv_owner, e_rd0, e_rd1);
      end
      @(posedge HCLK);
      m_rv_valid = 1'b0;
      if (w < 0) begin
        m_streak = 0;
      end else begin
        if (p_we[w] == 4'b0000) begin
          m_rv_valid = 1'b1; m_rv_owner = w; m_rv_data = ref_mem[p_addr[w]];
        end else begin
          tmp = ref_mem[p_addr[w]];
          for (int b = 0; b < 4; b++) if (p_we[w][b]) tmp[8*b +: 8] = p_wdata[w][8*b +: 8];
          ref_mem[p_addr[w]] = tmp;
        end
        if (w == m_last && m_streak > 0) m_streak = (m_streak < MAX_HOLD) ? m_streak + 1 : MAX_HOLD;
        else                             m_streak = 1;
        m_last   = w;
        p_act[w] = 1'b0;
      end
      #1;
    end
    drive_idle();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    drive_idle();
    test_reset();
    test_single_read();
    test_contention();
    test_partial_write();
    test_alternating_reads();
    test_reset_mid_read();
    test_idle_gap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
